fe_phy_sequencer: RTL and testbench

Sequences the USB front-end PHY (USB3300-class ULPI/UTMI transceiver) configuration pins: issues the power-up PHY reset, resolves the effective bus speed from the register-selected speed and the autodetect result, applies xcvrsel/termsel and waits a settle interval. It then flags the PHY as ready so capture can be armed. It sits between the register block / autodetect logic and the front-end output pins, in the USB register clock domain, because the PHY clock is not guaranteed during PHY reset.

---
 rtl/fe_phy_sequencer.sv | 168 ++++++++++++++++
 tb/tb_fe_phy_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fe_phy_sequencer.sv
// fe_phy_sequencer: drives the USB front-end PHY configuration pins.
// Runs the power-up PHY reset, resolves the effective bus speed, applies
// xcvrsel/termsel, waits out a settle interval, then reports ready.
// Build option: define FE_PHY_RESET_EN to include the PHY reset phase;
// without it the PHY reset pin is held low and INIT goes straight to APPLY.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// INIT     | one idle cycle after reset or restart
// PHY_RST  | PHY reset pin asserted for pRESET_CYCLES cycles
// APPLY    | latch target xcvrsel/termsel onto the pins, load settle timer
// SETTLE   | wait pSETTLE_CYCLES; a config change re-enters APPLY
// READY    | PHY configured and settled; a config change re-enters APPLY

module fe_phy_sequencer #(
    parameter int pRESET_CYCLES  = 64,
    parameter int pSETTLE_CYCLES = 1024
) (
    input  logic       cwusb_clk,
    input  logic       reset_i,
    input  logic [1:0] I_usb_speed,
    input  logic [1:0] I_auto_speed,
    input  logic [1:0] I_xcvrsel_auto,
    input  logic       I_termsel_auto,
    input  logic       I_restart,
    output logic       O_fe_reset,
    output logic [1:0] O_fe_xcvrsel,
    output logic       O_fe_termsel,
    output logic [1:0] O_fe_opmode,
    output logic       O_fe_suspendn,
    output logic       O_ready,
    output logic [2:0] O_state
);

    // Speed encodings shared with the register block
    localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
    localparam logic [1:0] USB_SPEED_LS   = 2'd1;
    localparam logic [1:0] USB_SPEED_FS   = 2'd2;
    localparam logic [1:0] USB_SPEED_HS   = 2'd3;

    localparam int CNT_MAX = (pRESET_CYCLES > pSETTLE_CYCLES) ? pRESET_CYCLES : pSETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SET_LOAD   = CNT_W'(pSETTLE_CYCLES - 1);
`ifdef FE_PHY_RESET_EN
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(pRESET_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_PHY_RST = 3'd1,
        ST_APPLY   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_READY   = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       eff_speed;
    logic [1:0]       tgt_xcvrsel;
    logic             tgt_termsel;
    logic [1:0]       xcvrsel_q;
    logic             termsel_q;
    logic             ready_q;
    logic             cfg_diff;

    // Resolve the effective speed and the pin configuration it calls for
    always_comb begin
        eff_speed   = I_usb_speed;
        tgt_xcvrsel = I_xcvrsel_auto;
        tgt_termsel = I_termsel_auto;
        if (I_usb_speed == USB_SPEED_AUTO)
            eff_speed = I_auto_speed;
        case (eff_speed)
            USB_SPEED_LS: begin tgt_xcvrsel = 2'b10; tgt_termsel = 1'b1; end
            USB_SPEED_FS: begin tgt_xcvrsel = 2'b01; tgt_termsel = 1'b1; end
            USB_SPEED_HS: begin tgt_xcvrsel = 2'b00; tgt_termsel = 1'b0; end
            default:      ;
        endcase
    end

    assign cfg_diff = ({tgt_xcvrsel, tgt_termsel} != {xcvrsel_q, termsel_q});

    // Next-state and timer logic; restart overrides any config change
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_INIT: begin
`ifdef FE_PHY_RESET_EN
                state_nxt = ST_PHY_RST;
                cnt_nxt   = RST_LOAD;
`else
                state_nxt = ST_APPLY;
`endif
            end
            ST_PHY_RST: begin
                if (cnt == '0)
                    state_nxt = ST_APPLY;
                else
                    cnt_nxt = cnt - CNT_ONE;
            end
            ST_APPLY: begin
                state_nxt = ST_SETTLE;
                cnt_nxt   = SET_LOAD;
            end
            ST_SETTLE: begin
                if (cfg_diff)
                    state_nxt = ST_APPLY;
                else if (cnt == '0)
                    state_nxt = ST_READY;
                else
                    cnt_nxt = cnt - CNT_ONE;
            end
            ST_READY: begin
                if (cfg_diff)
                    state_nxt = ST_APPLY;
            end
            default: state_nxt = ST_INIT;
        endcase
        if (I_restart && (state != ST_INIT))
            state_nxt = ST_INIT;
    end

    // State, timer and registered output pins
    always_ff @(posedge cwusb_clk) begin
        if (reset_i) begin
            state     <= ST_INIT;
            cnt       <= '0;
            xcvrsel_q <= 2'b01;
            termsel_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == ST_READY);
            if (state == ST_APPLY) begin
                xcvrsel_q <= tgt_xcvrsel;
                termsel_q <= tgt_termsel;
            end
        end
    end

`ifdef FE_PHY_RESET_EN
    logic fe_reset_q;

    // PHY reset pin follows the state the sequencer is about to enter
    always_ff @(posedge cwusb_clk) begin
        if (reset_i)
            fe_reset_q <= 1'b1;
        else
            fe_reset_q <= (state_nxt == ST_PHY_RST);
    end

    assign O_fe_reset = fe_reset_q;
`else
    assign O_fe_reset = 1'b0;
`endif

    assign O_fe_xcvrsel  = xcvrsel_q;
    assign O_fe_termsel  = termsel_q;
    assign O_fe_opmode   = 2'b01;
    assign O_fe_suspendn = 1'b1;
    assign O_ready       = ready_q;
    assign O_state       = state;

endmodule

// File: tb/tb_fe_phy_sequencer.sv
// tb_fe_phy_sequencer: scoreboard bench for fe_phy_sequencer (default parameters).
// Expected pin values are queued against absolute cycle numbers when stimulus
// is driven and compared on the falling edge of the matching cycle.

module tb_fe_phy_sequencer;

    localparam int R = 64;
    localparam int S = 1024;
`ifdef FE_PHY_RESET_EN
    localparam int A     = R + 1;
    localparam int FR_ON = 1;
`else
    localparam int A     = 1;
    localparam int FR_ON = 0;
`endif

    localparam logic [1:0] SP_AUTO = 2'd0;
    localparam logic [1:0] SP_LS   = 2'd1;
    localparam logic [1:0] SP_FS   = 2'd2;
    localparam logic [1:0] SP_HS   = 2'd3;

    localparam int W_RDY = 0, W_ST = 1, W_XS = 2, W_TS = 3, W_FR = 4, W_OP = 5, W_SN = 6;

    logic       cwusb_clk = 1'b0;
    logic       reset_i;
    logic [1:0] I_usb_speed;
    logic [1:0] I_auto_speed;
    logic [1:0] I_xcvrsel_auto;
    logic       I_termsel_auto;
    logic       I_restart;
    logic       O_fe_reset;
    logic [1:0] O_fe_xcvrsel;
    logic       O_fe_termsel;
    logic [1:0] O_fe_opmode;
    logic       O_fe_suspendn;
    logic       O_ready;
    logic [2:0] O_state;

    fe_phy_sequencer dut (
        .cwusb_clk      (cwusb_clk),
        .reset_i        (reset_i),
        .I_usb_speed    (I_usb_speed),
        .I_auto_speed   (I_auto_speed),
        .I_xcvrsel_auto (I_xcvrsel_auto),
        .I_termsel_auto (I_termsel_auto),
        .I_restart      (I_restart),
        .O_fe_reset     (O_fe_reset),
        .O_fe_xcvrsel   (O_fe_xcvrsel),
        .O_fe_termsel   (O_fe_termsel),
        .O_fe_opmode    (O_fe_opmode),
        .O_fe_suspendn  (O_fe_suspendn),
        .O_ready        (O_ready),
        .O_state        (O_state)
    );

    always #5 cwusb_clk = ~cwusb_clk;

    typedef struct {
        int    cyc;
        int    what;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   gcyc   = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge cwusb_clk) gcyc <= gcyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, gcyc);
    endtask

    function automatic int obs(input int what);
        case (what)
            W_RDY:   return int'(O_ready);
            W_ST:    return int'(O_state);
            W_XS:    return int'(O_fe_xcvrsel);
            W_TS:    return int'(O_fe_termsel);
            W_FR:    return int'(O_fe_reset);
            W_OP:    return int'(O_fe_opmode);
            default: return int'(O_fe_suspendn);
        endcase
    endfunction

    task automatic ex(input int cyc, input int what, input int val, input string tag);
        exp_t e;
        e.cyc  = cyc;
        e.what = what;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int cyc);
        while (gcyc < cyc) begin
            @(posedge cwusb_clk);
            #1;
        end
    endtask

    // Compare every queued expectation that falls due in the current cycle
    always @(negedge cwusb_clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == gcyc) begin
                chk(sb[i].tag, obs(sb[i].what), sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b, c, d, m;
        reset_i        = 1'b1;
        I_usb_speed    = SP_FS;
        I_auto_speed   = SP_AUTO;
        I_xcvrsel_auto = 2'b00;
        I_termsel_auto = 1'b0;
        I_restart      = 1'b0;
        repeat (3) @(posedge cwusb_clk);
        #1;

        // reset values
        c = gcyc;
        ex(c, W_ST, 0, "rst_state");
        ex(c, W_RDY, 0, "rst_ready");
        ex(c, W_FR, FR_ON, "rst_fe_reset");
        ex(c, W_XS, 1, "rst_xcvrsel");
        ex(c, W_TS, 1, "rst_termsel");
        ex(c, W_OP, 1, "rst_opmode");
        ex(c, W_SN, 1, "rst_suspendn");
        wait_until(c + 2);

        // power-up sequence at FS
        reset_i = 1'b0;
        b = gcyc;
        ex(b, W_ST, 0, "s1_init");
        ex(b, W_FR, FR_ON, "s1_fr_c0");
`ifdef FE_PHY_RESET_EN
        ex(b + 1, W_ST, 1, "s1_phy_rst");
        ex(b + R, W_FR, 1, "s1_fr_last");
        ex(b + R, W_ST, 1, "s1_phy_rst_last");
        ex(b + R + 1, W_FR, 0, "s1_fr_off");
`endif
        ex(b + A, W_ST, 2, "s1_apply");
        ex(b + A + 1, W_ST, 3, "s1_settle");
        ex(b + A + S, W_RDY, 0, "s1_ready_early");
        ex(b + A + S + 1, W_RDY, 1, "s1_ready");
        ex(b + A + S + 1, W_ST, 4, "s1_state_ready");
        ex(b + A + S + 1, W_XS, 1, "s1_xcvrsel");
        ex(b + A + S + 1, W_TS, 1, "s1_termsel");
        wait_until(b + A + S + 5);

        // FS -> HS while READY
        c = gcyc;
        I_usb_speed = SP_HS;
        ex(c, W_RDY, 1, "s2_ready_before");
        ex(c + 1, W_RDY, 0, "s2_ready_drop");
        ex(c + 1, W_ST, 2, "s2_apply");
        ex(c + 1, W_XS, 1, "s2_xcvrsel_hold");
        ex(c + 2, W_XS, 0, "s2_xcvrsel_hs");
        ex(c + 2, W_TS, 0, "s2_termsel_hs");
        ex(c + 2, W_ST, 3, "s2_settle");
        ex(c + 2, W_FR, 0, "s2_fe_reset");
        ex(c + S + 1, W_RDY, 0, "s2_ready_early");
        ex(c + S + 2, W_RDY, 1, "s2_ready");
        wait_until(c + S + 5);

        // AUTO speed, undetermined, then autodetect reports HS
        c = gcyc;
        I_usb_speed    = SP_AUTO;
        I_auto_speed   = SP_AUTO;
        I_xcvrsel_auto = 2'b10;
        I_termsel_auto = 1'b1;
        ex(c + 2, W_XS, 2, "s3_xcvrsel_auto");
        ex(c + 2, W_TS, 1, "s3_termsel_auto");
        ex(c + S + 1, W_RDY, 0, "s3_ready_early");
        ex(c + S + 2, W_RDY, 1, "s3_ready");
        wait_until(c + S + 5);
        d = gcyc;
        I_auto_speed = SP_HS;
        ex(d + 1, W_RDY, 0, "s3_det_drop");
        ex(d + 2, W_XS, 0, "s3_det_xcvrsel");
        ex(d + 2, W_TS, 0, "s3_det_termsel");
        ex(d + S + 1, W_RDY, 0, "s3_det_early");
        ex(d + S + 2, W_RDY, 1, "s3_det_ready");
        wait_until(d + S + 5);

        // change to LS, then to FS 500 cycles into the settle
        c = gcyc;
        I_usb_speed = SP_LS;
        ex(c + 2, W_XS, 2, "s4_xcvrsel_ls");
        ex(c + 2, W_TS, 1, "s4_termsel_ls");
        m = c + 2 + 500;
        ex(c + S + 2, W_RDY, 0, "s4_no_early_ready");
        wait_until(m);
        I_usb_speed = SP_FS;
        ex(m, W_ST, 3, "s4_mid_settle");
        ex(m + 1, W_ST, 2, "s4_reapply");
        ex(m + 2, W_XS, 1, "s4_xcvrsel_fs");
        ex(m + S + 1, W_RDY, 0, "s4_ready_early");
        ex(m + S + 2, W_RDY, 1, "s4_ready");
        wait_until(m + S + 5);

        // restart coincident with FS -> HS
        c = gcyc;
        I_restart   = 1'b1;
        I_usb_speed = SP_HS;
        ex(c + 1, W_ST, 0, "s5_init");
        ex(c + 1, W_RDY, 0, "s5_ready_drop");
`ifdef FE_PHY_RESET_EN
        ex(c + 1, W_FR, 0, "s5_fr_init");
        ex(c + 2, W_FR, 1, "s5_fr_on");
        ex(c + 2, W_ST, 1, "s5_phy_rst");
        ex(c + R + 1, W_FR, 1, "s5_fr_last");
        ex(c + R + 2, W_FR, 0, "s5_fr_off");
`endif
        ex(c + 1 + A, W_ST, 2, "s5_apply");
        ex(c + 1 + A, W_XS, 1, "s5_xcvrsel_hold");
        ex(c + A + 2, W_XS, 0, "s5_xcvrsel_hs");
        ex(c + A + 2, W_TS, 0, "s5_termsel_hs");
        ex(c + A + S + 1, W_RDY, 0, "s5_ready_early");
        ex(c + A + S + 2, W_RDY, 1, "s5_ready");
        wait_until(c + 1);
        I_restart = 1'b0;
        wait_until(c + A + S + 5);

        // restart, then reset_i pulsed part-way through the re-sequence
        c = gcyc;
        I_restart = 1'b1;
        wait_until(c + 1);
        I_restart = 1'b0;
        ex(c + 20, W_XS, 0, "s6_xcvrsel_pre");
        ex(c + 21, W_ST, 0, "s6_rst_state");
        ex(c + 21, W_XS, 1, "s6_rst_xcvrsel");
        ex(c + 21, W_TS, 1, "s6_rst_termsel");
        ex(c + 21, W_RDY, 0, "s6_rst_ready");
        ex(c + 21, W_FR, FR_ON, "s6_rst_fe_reset");
        wait_until(c + 20);
        reset_i = 1'b1;
        wait_until(c + 23);
        reset_i = 1'b0;
        b = gcyc;
        ex(b, W_ST, 0, "s6_init");
        ex(b + 30, W_FR, FR_ON, "s6_fe_reset");
        ex(b + A, W_XS, 1, "s6_xcvrsel_hold");
        ex(b + A + 1, W_XS, 0, "s6_xcvrsel_hs");
        ex(b + A + S, W_RDY, 0, "s6_ready_early");
        ex(b + A + S + 1, W_RDY, 1, "s6_ready");
        ex(b + A + S + 1, W_FR, 0, "s6_fe_reset_ready");
        wait_until(b + A + S + 5);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
